// File: rtl/ex_muldiv_if.sv
// Valid/ready bundle between the execute stage and the mul/div unit.
// The master side is the execute stage; the slave side is the unit.
interface ex_muldiv_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             hold;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag,
    output hold, flush, out_ready,
    input  in_ready, out_valid, out_result,
    input  out_tag, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag,
    input  hold, flush, out_ready,
    output in_ready, out_valid, out_result,
    output out_tag, busy
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M/RV64M multi-cycle multiply/divide unit for the execute stage.
// MULDIV_EARLY_OUT_EN: short-cut divides whose quotient is zero.
module ex_muldiv_unit #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4,
  parameter int TAG_W       = 5
) (
  input  logic        clock,
  input  logic        reset,
  ex_muldiv_if.slave  io
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam int CW = $clog2(XLEN);
  localparam int MCNT =
    (MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [XLEN-1:0]  res_q, res_d;

  logic idle;
  assign idle = (state_q == S_IDLE);

  assign io.in_ready   = idle && !io.hold;
  assign io.busy       = !idle;
  assign io.out_valid  = (state_q == S_DONE);
  assign io.out_result = res_q;
  assign io.out_tag    = tag_q;

  // With MUL_LATENCY=1 the product is taken straight from the inputs.
  logic [XLEN-1:0]   ma, mb;
  logic [2:0]        mop;
  logic              sa, sb;
  logic [2*XLEN-1:0] xa, xb, prod;
  logic [XLEN-1:0]   mul_res;

  always_comb begin
    ma  = idle ? io.in_a  : a_q;
    mb  = idle ? io.in_b  : b_q;
    mop = idle ? io.in_op : op_q;
    sa  = (mop == 3'd1) || (mop == 3'd2);
    sb  = (mop == 3'd1);
    xa  = {{XLEN{sa & ma[XLEN-1]}}, ma};
    xb  = {{XLEN{sb & mb[XLEN-1]}}, mb};
    prod = xa * xb;
    mul_res = (mop == 3'd0) ? prod[XLEN-1:0]
                            : prod[2*XLEN-1:XLEN];
  end

  logic            dsgn, a_neg, b_neg;
  logic            b_zero, ovf, is_rem;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    dsgn   = !io.in_op[0];
    is_rem = io.in_op[1];
    a_neg  = dsgn & io.in_a[XLEN-1];
    b_neg  = dsgn & io.in_b[XLEN-1];
    a_mag  = a_neg ? -io.in_a : io.in_a;
    b_mag  = b_neg ? -io.in_b : io.in_b;
    b_zero = (io.in_b == '0);
    ovf    = dsgn
          && (io.in_a == {1'b1, {(XLEN-1){1'b0}}})
          && (io.in_b == '1);
    if (b_zero)
      spec_res = is_rem ? io.in_a : '1;
    else
      spec_res = is_rem ? '0 : io.in_a;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract.
  logic [XLEN-1:0] s_rem, s_dvd, s_b;
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] nrem, ndvd;

  always_comb begin
    s_rem = idle ? '0    : rem_q;
    s_dvd = idle ? a_mag : dvd_q;
    s_b   = idle ? b_mag : b_q;
    trial = {s_rem, s_dvd[XLEN-1]};
    ge    = (trial >= {1'b0, s_b});
    nrem  = ge ? (trial[XLEN-1:0] - s_b)
               : trial[XLEN-1:0];
    ndvd  = {s_dvd[XLEN-2:0], ge};
  end

  logic [XLEN-1:0] fix_q, fix_r;
  assign fix_q = qneg_q ? -dvd_q : dvd_q;
  assign fix_r = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tag_d   = tag_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    if (!io.hold) begin
      if (io.flush) begin
        state_d = S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: if (io.in_valid) begin
            a_d   = io.in_a;
            b_d   = io.in_b;
            op_d  = io.in_op;
            tag_d = io.in_tag;
            if (!io.in_op[2]) begin
              if (MUL_LATENCY == 1) begin
                state_d = S_DONE;
                res_d   = mul_res;
              end else begin
                state_d = S_MUL;
                cnt_d   = CW'(MCNT);
              end
            end else if (b_zero || ovf) begin
              state_d = S_DONE;
              res_d   = spec_res;
            end else if (EARLY && !dsgn &&
                         io.in_a < io.in_b) begin
              state_d = S_DONE;
              res_d   = is_rem ? io.in_a : '0;
            end else begin
              b_d    = b_mag;
              qneg_d = a_neg ^ b_neg;
              rneg_d = a_neg;
              if (EARLY && dsgn && a_mag < b_mag) begin
                state_d = S_FIX;
                dvd_d   = '0;
                rem_d   = a_mag;
              end else begin
                state_d = S_DIV;
                cnt_d   = CW'(XLEN - 2);
                dvd_d   = ndvd;
                rem_d   = nrem;
              end
            end
          end
          S_MUL: begin
            if (cnt_q == '0) begin
              state_d = S_DONE;
              res_d   = mul_res;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          S_DIV: begin
            dvd_d = ndvd;
            rem_d = nrem;
            if (cnt_q == '0)
              state_d = S_FIX;
            else
              cnt_d = cnt_q - 1'b1;
          end
          S_FIX: begin
            res_d   = op_q[1] ? fix_r : fix_q;
            state_d = S_DONE;
          end
          S_DONE: if (io.out_ready) state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: random ops against an
// arithmetic reference model, plus hold/flush/back-pressure cases.
module tb_ex_muldiv_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int ML    = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ex_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

  ex_muldiv_unit #(
    .XLEN(XLEN), .MUL_LATENCY(ML), .TAG_W(TAG_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(bus.slave)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b0;
  logic prev_v = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] ref_res(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    bit ov;
    sa = $signed(a);
    sb = $signed(b);
    ub = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[63:32];
      end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (ov) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (ov) r = 32'h0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    bit sgn;
    sa  = $signed(a);
    sb  = $signed(b);
    sgn = (op == 3'd4) || (op == 3'd6);
    if (op < 3'd4) return ML;
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!sgn && a < b) return 1;
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (sgn && sa < sb) return 2;
`endif
    return XLEN + 1;
  endfunction

  // Monitor: latency on the rising edge of out_valid, data on handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.out_valid && !prev_v) begin
        if (q.size() == 0)
          chk("unexpected_valid", 1, 0);
        else
          chk("latency", cyc - q[0].acc, q[0].lat);
      end
      if (bus.out_valid && bus.out_ready &&
          !bus.hold && !bus.flush && q.size() > 0) begin
        chk("result", bus.out_result, q[0].res);
        chk("tag", bus.out_tag, q[0].tag);
        void'(q.pop_front());
      end
    end
    prev_v = bus.out_valid;
  end

  always @(posedge clock) begin
    #1;
    if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
  end

  task automatic issue(logic [2:0] op, logic [31:0] a,
                       logic [31:0] b, logic [4:0] tag,
                       int extra = 0, bit push = 1'b1);
    int n;
    exp_t e;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) begin
      e.res = ref_res(op, a, b);
      e.tag = tag;
      e.lat = ref_lat(op, a, b) + extra;
      e.acc = cyc;
      q.push_back(e);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.out_result, 0);
    chk("rst_tag", bus.out_tag, 0);
    reset = 1'b0;
    chk("rst_in_ready", bus.in_ready, 1);

    // MUL 7 * -3 with the result held under back-pressure.
    bus.out_ready = 1'b0;
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    for (int i = 1; i <= 3; i++) begin
      chk("mul_in_ready", bus.in_ready, 0);
      tick();
    end
    chk("mul_valid_c4", bus.out_valid, 1);
    chk("mul_in_ready_c4", bus.in_ready, 0);
    repeat (3) begin
      chk("stall_result", bus.out_result, 32'hFFFF_FFEB);
      chk("stall_tag", bus.out_tag, 9);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("done_to_idle", bus.busy, 0);
    chk("idle_in_ready", bus.in_ready, 1);

    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    issue(3'd4, -32'sd20, 32'd3, 5'd4);
    issue(3'd6, -32'sd20, 32'd3, 5'd5);
    issue(3'd5, 32'd20, 32'd0, 5'd6);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    issue(3'd5, 32'd5, 32'd9, 5'd10);
    issue(3'd4, 32'd3, -32'sd7, 5'd11);
    drain();

    // Hold for 10 cycles mid-divide; a flush under hold is ignored.
    issue(3'd4, -32'sd20, 32'd3, 5'd12, 10);
    repeat (3) tick();
    bus.hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.flush = (i == 4);
      chk("hold_in_ready", bus.in_ready, 0);
      tick();
    end
    bus.hold  = 1'b0;
    bus.flush = 1'b0;
    drain();

    // Flush mid-divide: result must never appear.
    issue(3'd4, 32'd100, 32'd7, 5'd13, 0, 1'b0);
    repeat (11) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_in_ready", bus.in_ready, 1);
    chk("flush_busy", bus.busy, 0);
    repeat (40) tick();
    issue(3'd0, 32'h1234_5678, 32'h9abc_def0, 5'd14);
    drain();

    // Accept and flush in the same cycle: op dropped.
    bus.in_valid = 1'b1;
    bus.in_op    = 3'd0;
    bus.flush    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("accflush_busy", bus.busy, 0);
    chk("accflush_in_ready", bus.in_ready, 1);
    repeat (6) tick();

    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin
          a = 32'($urandom_range(0, 40)) - 32'd20;
          b = 32'($urandom_range(0, 14)) - 32'd7;
        end
        3: begin a = $urandom_range(0, 99); b = $urandom | 32'h100; end
        4: b = $urandom_range(1, 300);
        default: ;
      endcase
      issue(op, a, b, 5'($urandom_range(0, 31)));
    end
    drain();
    rdy_rand = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle RV32M/RV64M multiply/divide unit for the execute stage.
- Replaces the fixed-countdown multiply stall with real arithmetic:
  - MUL* ops: parametrised latency.
  - DIV/REM ops: bit-serial divider.
- Valid/ready on both sides. Execute stage holds its pipeline register while `in_valid && !in_ready` or while a result is pending.
- Global cache stall (`hold`) freezes the unit; branch `flush` kills it.

Parameters:
- XLEN, 32, operand/result width; must be 32 or 64.
- MUL_LATENCY, 4, cycles from accept to `out_valid` for MUL-class ops; legal range 1..8.
- TAG_W, 5, width of the destination-register tag carried with the op.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  op presented
- in_ready  output  1  unit can accept (state IDLE)
- in_op  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_a  input  XLEN  rs1 value, already forwarded
- in_b  input  XLEN  rs2 value, already forwarded
- in_tag  input  TAG_W  destination register select
- hold  input  1  icache/dcache stall; freezes all state
- flush  input  1  kill in-flight op
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_result  output  XLEN  result
- out_tag  output  TAG_W  tag of the result
- busy  output  1  state != IDLE

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; `out_valid`=0, `out_result`=0, `out_tag`=0, `busy`=0; counters=0.
  - `in_ready`=1 from the first cycle after reset deasserts.
- States: IDLE, MUL, DIV, FIX, DONE.
  - IDLE: accept when `in_valid && in_ready && !hold && !flush`. Latch a, b, op, tag.
    - op<4 -> MUL, cnt=MUL_LATENCY-1.
    - op>=4, divisor zero or signed overflow -> DONE directly; result visible next cycle (latency 1).
    - otherwise -> DIV, cnt=XLEN-1.
  - MUL: full 2*XLEN product of sign/zero-extended operands.
    - MULH treats both operands signed; MULHSU treats a signed, b unsigned; MULHU treats both unsigned.
    - Decrement cnt each cycle; at cnt==0 go to DONE.
    - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
    - Accept-to-`out_valid` latency = MUL_LATENCY cycles exactly.
    - MUL_LATENCY=1 -> MUL state skipped; DONE next cycle.
  - DIV: restoring radix-2 on magnitudes, one quotient bit per cycle, XLEN cycles, then FIX.
  - FIX (1 cycle): apply signs.
    - Quotient negative iff signs of a and b differ (signed ops).
    - Remainder takes the sign of a.
    - Then DONE. Total DIV latency = XLEN+1 cycles (33 for XLEN=32).
  - DONE: `out_valid`=1; `out_result`/`out_tag` stable.
    - When `out_ready && !hold`: go to IDLE. `in_ready` rises the following cycle (no same-cycle re-accept).
- Special cases (RISC-V M semantics):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a.
  - Signed overflow (a = most negative, b = -1): DIV = a; REM = 0.
- `hold`=1: no state, counter, or output register changes. `in_ready` forced 0. `out_valid` keeps its value.
- `flush`=1 (when `hold`=0): next state IDLE, `out_valid`=0. Any in-flight or DONE result is discarded.
  - Flush wins over a same-cycle accept and over a same-cycle `out_ready`.
- `flush` and `hold` together: `hold` wins; the flush is ignored. The execute stage must re-assert flush after the hold clears.
- `in_a`/`in_b` may change after accept; only latched copies are used.
- `out_result` holds its last value in IDLE (not cleared).

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined:
  - DIVU/REMU with a < b (unsigned) skip DIV and FIX: quotient 0, remainder a, latency 1.
  - Signed DIV/REM with |a| < |b| go directly to FIX: quotient 0, remainder a, latency 2.
- Undefined: every non-special divide takes exactly XLEN+1 cycles, giving data-independent timing.
- MUL timing is unchanged either way.

Test Plan:
- MUL, a=7, b=-3, MUL_LATENCY=4, accept at cycle 0 -> `out_valid` at cycle 4, `out_result`=0xFFFFFFEB, `out_tag` echoed; `in_ready`=0 during cycles 1-4.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-20, b=3 -> 0xFFFFFFFA after 33 cycles. REM a=-20, b=3 -> 0xFFFFFFFE. DIVU a=20, b=0 -> 0xFFFFFFFF at latency 1. DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
- DIV in flight, `hold` high for 10 cycles at cycle 5 -> `out_valid` at cycle 43 with the correct result; `in_ready` stays 0 throughout.
- `flush` at cycle 12 of a DIV -> `out_valid` never asserts; `in_ready`=1 at cycle 13. A new MUL accepted then completes in MUL_LATENCY cycles. Accept plus flush in the same cycle -> op dropped.
- DONE with `out_ready`=0 for 3 cycles -> result and tag stable; `out_ready`=1 -> IDLE next cycle. With MULDIV_EARLY_OUT_EN defined: DIVU 5/9 -> quotient 0 at latency 1.
